// File: rtl/stat_graph_render_pkg.sv
// Shared constants, channel colours and helpers for the multi-channel statistics graph.
package stat_graph_render_pkg;

  localparam int unsigned STAT_MAX_CHANNELS = 4;
  localparam int unsigned SCREEN_WIDTH      = 1024;
  localparam int unsigned SCREEN_HEIGHT     = 768;
  localparam int unsigned SCALE_W           = 5;

  typedef logic [11:0] stat_color_t;

  localparam stat_color_t AXIS_COLOR = 12'hFFF;
  localparam stat_color_t STAT_COLORS [STAT_MAX_CHANNELS] =
    '{12'h0F0, 12'hF00, 12'h00F, 12'hFF0};

  // Smallest r with 2**r >= v; zero and one both map to 0.
  function automatic logic [SCALE_W:0] ceil_log2(input logic [31:0] v);
    logic [SCALE_W:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (v > (32'd1 << i)) r = (SCALE_W + 1)'(i + 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/stat_graph_render_if.sv
// Raster, event and pixel signals between the render pipeline and the statistics graph.
interface stat_graph_render_if #(
  parameter int unsigned CHANNELS = 2
);
  logic [10:0]         hcount_in;
  logic [9:0]          vcount_in;
  logic [CHANNELS-1:0] inc_in;
  logic                frame_end_in;
  logic                clear_in;
  logic [11:0]         pix_out;
  logic [4:0]          scale_out;

  modport master (
    output hcount_in, vcount_in, inc_in, frame_end_in, clear_in,
    input  pix_out, scale_out
  );

  modport slave (
    input  hcount_in, vcount_in, inc_in, frame_end_in, clear_in,
    output pix_out, scale_out
  );
endinterface

// File: rtl/stat_graph_render_history.sv
// Per-channel saturating accumulator with a ring buffer of committed samples.
module stat_history #(
  parameter int unsigned TALLY_W     = 16,
  parameter int unsigned HISTORY_LEN = 25,
  parameter int unsigned PTR_W       = 5
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               clear_i,
  input  logic               acc_en_i,
  input  logic               inc_i,
  input  logic               commit_i,
  input  logic [PTR_W-1:0]   wr_ptr_i,
  input  logic [PTR_W-1:0]   rd_slot_i,
  output logic [TALLY_W-1:0] rd_data_o,
  output logic [TALLY_W-1:0] commit_val_o
);

  logic [TALLY_W-1:0] acc_q, acc_d;
  logic [TALLY_W-1:0] acc_sat;
  logic [TALLY_W:0]   sum;
  logic [TALLY_W-1:0] hist_q [HISTORY_LEN];

  always_comb begin
    sum     = {1'b0, acc_q} + {{TALLY_W{1'b0}}, inc_i};
    acc_sat = sum[TALLY_W] ? '1 : sum[TALLY_W-1:0];
    acc_d   = acc_q;
    if (commit_i)      acc_d = '0;
    else if (acc_en_i) acc_d = acc_sat;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_q <= '0;
      for (int unsigned i = 0; i < HISTORY_LEN; i++) hist_q[i] <= '0;
    end else if (clear_i) begin
      acc_q <= '0;
      for (int unsigned i = 0; i < HISTORY_LEN; i++) hist_q[i] <= '0;
    end else begin
      acc_q <= acc_d;
      if (commit_i) hist_q[wr_ptr_i] <= acc_sat;
    end
  end

  assign commit_val_o = acc_sat;
  assign rd_data_o    = hist_q[rd_slot_i];

endmodule

// File: rtl/stat_graph_render.sv
// Multi-channel statistics graph: frame divider, ring pointers, auto-scale and pixel compositor.
// Define STAT_GRAPH_FILL_EN to fill each trace column down to the axis instead of plotting points.
module stat_graph_render
  import stat_graph_render_pkg::*;
#(
  parameter int unsigned CHANNELS       = 2,
  parameter int unsigned HISTORY_LEN    = 25,
  parameter int unsigned SAMPLE_PIX     = 8,
  parameter int unsigned GRAPH_HEIGHT   = 200,
  parameter int unsigned GRAPH_ORIGIN_X = 800,
  parameter int unsigned GRAPH_ORIGIN_Y = 32,
  parameter int unsigned TALLY_W        = 16,
  parameter int unsigned LOG_FRAME_DIV  = 5
) (
  input logic                clk_130mhz,
  input logic                rst_n_in,
  stat_graph_render_if.slave gfx
);

  localparam int unsigned GRAPH_WIDTH = HISTORY_LEN * SAMPLE_PIX;
  localparam int unsigned X_END       = GRAPH_ORIGIN_X + GRAPH_WIDTH;
  localparam int unsigned Y_END       = GRAPH_ORIGIN_Y + GRAPH_HEIGHT;
  localparam int unsigned PTR_W       = (HISTORY_LEN > 1) ? $clog2(HISTORY_LEN) : 1;
  localparam int unsigned FILL_W      = $clog2(HISTORY_LEN + 1);
  localparam int unsigned FC_W        = (LOG_FRAME_DIV > 0) ? LOG_FRAME_DIV : 1;
  localparam int unsigned MUL_W       = TALLY_W + 8;

  logic [FC_W-1:0]    frame_cnt_q, frame_cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [SCALE_W-1:0] k_q, k_d, k_commit;
  logic [11:0]        pix_q, pix_d;

  logic               sample_phase, commit;
  logic [TALLY_W-1:0] vmax;
  logic [TALLY_W-1:0] rd_data    [CHANNELS];
  logic [TALLY_W-1:0] commit_val [CHANNELS];
  logic [31:0]        trace_row  [CHANNELS];
  logic [CHANNELS-1:0] trace_hit;

  logic [31:0]        hc, vc, idx, slot;
  logic               in_x, in_y, col_valid, axis_hit, hit_found;
  logic [PTR_W-1:0]   rd_slot;

  assign sample_phase = (frame_cnt_q == '0);
  assign commit       = gfx.frame_end_in && sample_phase && !gfx.clear_in;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [MUL_W-1:0] prod, scaled;

    stat_history #(
      .TALLY_W    (TALLY_W),
      .HISTORY_LEN(HISTORY_LEN),
      .PTR_W      (PTR_W)
    ) u_hist (
      .clk_i       (clk_130mhz),
      .rst_n_i     (rst_n_in),
      .clear_i     (gfx.clear_in),
      .acc_en_i    (sample_phase),
      .inc_i       (gfx.inc_in[c]),
      .commit_i    (commit),
      .wr_ptr_i    (wr_ptr_q),
      .rd_slot_i   (rd_slot),
      .rd_data_o   (rd_data[c]),
      .commit_val_o(commit_val[c])
    );

    assign prod         = MUL_W'(rd_data[c]) * MUL_W'(GRAPH_HEIGHT);
    assign scaled       = prod >> k_q;
    assign trace_row[c] = Y_END - ((scaled > MUL_W'(GRAPH_HEIGHT)) ? GRAPH_HEIGHT : 32'(scaled));
`ifdef STAT_GRAPH_FILL_EN
    assign trace_hit[c] = (vc >= trace_row[c]);
`else
    assign trace_hit[c] = (vc == trace_row[c]);
`endif
  end

  always_comb begin
    vmax = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (commit_val[c] > vmax) vmax = commit_val[c];
    end
    k_commit = SCALE_W'(ceil_log2(32'(vmax)));

    frame_cnt_d = frame_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    k_d         = k_q;
    if (gfx.frame_end_in) begin
      frame_cnt_d = (LOG_FRAME_DIV == 0) ? '0 : frame_cnt_q + FC_W'(1);
    end
    if (commit) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(HISTORY_LEN - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      if (fill_q != FILL_W'(HISTORY_LEN)) fill_d = fill_q + FILL_W'(1);
      if (k_commit > k_q) k_d = k_commit;
    end
  end

  // Oldest sample sits at display index 0; idx < fill keeps the slot sum below 2*HISTORY_LEN.
  always_comb begin
    hc        = 32'(gfx.hcount_in);
    vc        = 32'(gfx.vcount_in);
    in_x      = (hc > GRAPH_ORIGIN_X) && (hc < X_END);
    in_y      = (vc > GRAPH_ORIGIN_Y) && (vc < Y_END);
    idx       = (hc - GRAPH_ORIGIN_X) / SAMPLE_PIX;
    col_valid = in_x && in_y && (idx < 32'(fill_q));
    slot      = 32'(wr_ptr_q) + HISTORY_LEN - 32'(fill_q) + idx;
    if (slot >= HISTORY_LEN) slot = slot - HISTORY_LEN;
    rd_slot   = col_valid ? PTR_W'(slot) : '0;
    axis_hit  = ((vc == Y_END) && in_x) || ((hc == GRAPH_ORIGIN_X) && in_y);
  end

  always_comb begin
    pix_d     = '0;
    hit_found = 1'b0;
    if (axis_hit) begin
      pix_d = AXIS_COLOR;
    end else if (col_valid) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (!hit_found && trace_hit[c]) begin
          pix_d     = STAT_COLORS[c];
          hit_found = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_130mhz or negedge rst_n_in) begin
    if (!rst_n_in) begin
      frame_cnt_q <= '0;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      k_q         <= '0;
      pix_q       <= '0;
    end else if (gfx.clear_in) begin
      frame_cnt_q <= '0;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      k_q         <= '0;
      pix_q       <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      k_q         <= k_d;
      pix_q       <= pix_d;
    end
  end

  assign gfx.pix_out   = pix_q;
  assign gfx.scale_out = k_q;

endmodule

// File: tb/tb_stat_graph_render.sv
// Directed plus randomized bench for stat_graph_render against a queue-based sample model.
module tb_stat_graph_render;

  localparam int unsigned CH  = 2;
  localparam int unsigned HL  = 25;
  localparam int unsigned SP  = 8;
  localparam int unsigned GH  = 200;
  localparam int unsigned OX  = 800;
  localparam int unsigned OY  = 32;
  localparam int unsigned TW  = 8;
  localparam int unsigned LFD = 5;
  localparam int unsigned GW  = HL * SP;
  localparam int unsigned SAT = (1 << TW) - 1;
  localparam logic [11:0] TB_COL [4] = '{12'h0F0, 12'hF00, 12'h00F, 12'hFF0};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #4 clk = ~clk;

  stat_graph_render_if #(.CHANNELS(CH)) gfx ();

  stat_graph_render #(
    .CHANNELS      (CH),
    .HISTORY_LEN   (HL),
    .SAMPLE_PIX    (SP),
    .GRAPH_HEIGHT  (GH),
    .GRAPH_ORIGIN_X(OX),
    .GRAPH_ORIGIN_Y(OY),
    .TALLY_W       (TW),
    .LOG_FRAME_DIV (LFD)
  ) dut (
    .clk_130mhz(clk),
    .rst_n_in  (rst_n),
    .gfx       (gfx)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int unsigned m_acc [CH];
  int unsigned m_fc;
  int unsigned m_k;
  int unsigned m_h0 [$];
  int unsigned m_h1 [$];

  function automatic int unsigned hist_at(int unsigned c, int unsigned i);
    return (c == 0) ? m_h0[i] : m_h1[i];
  endfunction

  function automatic int unsigned model_row(int unsigned c, int unsigned i);
    int unsigned hgt;
    hgt = (hist_at(c, i) * GH) >> m_k;
    if (hgt > GH) hgt = GH;
    return OY + GH - hgt;
  endfunction

  function automatic logic [11:0] model_pix(int unsigned x, int unsigned y);
    bit in_x, in_y;
    int unsigned i, row;
    in_x = (x > OX) && (x < OX + GW);
    in_y = (y > OY) && (y < OY + GH);
    if ((y == OY + GH) && in_x) return 12'hFFF;
    if ((x == OX) && in_y) return 12'hFFF;
    if (!(in_x && in_y)) return 12'h000;
    i = (x - OX) / SP;
    if (i >= m_h0.size()) return 12'h000;
    for (int unsigned c = 0; c < CH; c++) begin
      row = model_row(c, i);
`ifdef STAT_GRAPH_FILL_EN
      if (y >= row) return TB_COL[c];
`else
      if (y == row) return TB_COL[c];
`endif
    end
    return 12'h000;
  endfunction

  task automatic model_clear();
    for (int unsigned c = 0; c < CH; c++) m_acc[c] = 0;
    m_fc = 0;
    m_k  = 0;
    m_h0.delete();
    m_h1.delete();
  endtask

  task automatic model_edge(logic [CH-1:0] inc, bit fe, bit clr);
    int unsigned v [CH];
    if (clr) begin
      model_clear();
      return;
    end
    if (m_fc == 0) begin
      for (int unsigned c = 0; c < CH; c++) begin
        v[c] = m_acc[c] + inc[c];
        if (v[c] > SAT) v[c] = SAT;
      end
      if (fe) begin
        m_h0.push_back(v[0]);
        m_h1.push_back(v[1]);
        if (m_h0.size() > HL) begin
          void'(m_h0.pop_front());
          void'(m_h1.pop_front());
        end
        for (int unsigned c = 0; c < CH; c++) begin
          while ((32'd1 << m_k) < v[c]) m_k++;
          m_acc[c] = 0;
        end
      end else begin
        for (int unsigned c = 0; c < CH; c++) m_acc[c] = v[c];
      end
    end
    if (fe) m_fc = (m_fc + 1) % (1 << LFD);
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(logic [CH-1:0] inc, bit fe, bit clr);
    @(negedge clk);
    gfx.inc_in       = inc;
    gfx.frame_end_in = fe;
    gfx.clear_in     = clr;
    @(posedge clk);
    model_edge(inc, fe, clr);
  endtask

  task automatic drive_pix(int unsigned x, int unsigned y);
    @(negedge clk);
    gfx.hcount_in    = 11'(x);
    gfx.vcount_in    = 10'(y);
    gfx.inc_in       = '0;
    gfx.frame_end_in = 1'b0;
    gfx.clear_in     = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic pix_check(string tag, int unsigned x, int unsigned y);
    drive_pix(x, y);
    chk(tag, 32'(gfx.pix_out), 32'(model_pix(x, y)));
  endtask

  task automatic pix_expect(string tag, int unsigned x, int unsigned y, logic [11:0] exp);
    drive_pix(x, y);
    chk(tag, 32'(gfx.pix_out), 32'(exp));
  endtask

  task automatic scan(string tag);
    int unsigned x, row;
    for (int unsigned i = 0; i < m_h0.size(); i++) begin
      for (int unsigned c = 0; c < CH; c++) begin
        x   = OX + i * SP + 1 + $urandom_range(SP - 2, 0);
        row = model_row(c, i);
        pix_check(tag, x, row);
        pix_check(tag, x, row - 1);
      end
    end
    for (int n = 0; n < 8; n++) begin
      pix_check(tag, $urandom_range(OX + GW + 4, OX - 4), $urandom_range(OY + GH + 4, OY - 4));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    gfx.hcount_in    = '0;
    gfx.vcount_in    = '0;
    gfx.inc_in       = '0;
    gfx.frame_end_in = 1'b0;
    gfx.clear_in     = 1'b0;
    model_clear();

    repeat (3) @(posedge clk);
    #1;
    chk("reset_pix", 32'(gfx.pix_out), 32'h0);
    chk("reset_scale", 32'(gfx.scale_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    pix_expect("axis_bottom", 810, 232, 12'hFFF);
    pix_expect("axis_left", 800, 100, 12'hFFF);
    pix_expect("empty_plot", 820, 100, 12'h000);

    // single sample of 100 on channel 0
    repeat (100) step(2'b01, 1'b0, 1'b0);
    step(2'b00, 1'b1, 1'b0);
    #1 chk("one_k", 32'(gfx.scale_out), 32'd7);
    pix_expect("one_c801", 801, 76, 12'h0F0);
    pix_expect("one_c807", 807, 76, 12'h0F0);
    pix_expect("one_c808", 808, 76, 12'h000);
    pix_expect("one_c800", 800, 76, 12'hFFF);
    pix_check("one_below", 804, 150);
    scan("one_scan");

    // frames 1..31 of the divider: pulses must be ignored
    for (int f = 0; f < 31; f++) begin
      repeat (3) step(2'b11, 1'b0, 1'b0);
      step(2'b11, 1'b1, 1'b0);
    end
    #1 chk("div_k", 32'(gfx.scale_out), 32'd7);
    pix_expect("div_nocommit", 812, 76, 12'h000);

    // acc = 9 plus a same-cycle pulse commits 10
    repeat (9) step(2'b01, 1'b0, 1'b0);
    step(2'b01, 1'b1, 1'b0);
    pix_expect("simul_10", 809, 217, 12'h0F0);
    repeat (31) step(2'b00, 1'b1, 1'b0);
    step(2'b01, 1'b1, 1'b0);
    pix_expect("acc_cleared", 817, 231, 12'h0F0);
    scan("div_scan");

    // randomized sample periods
    step(2'b00, 1'b0, 1'b1);
    #1 chk("rand_clear_k", 32'(gfx.scale_out), 32'd0);
    for (int p = 0; p < 8; p++) begin
      repeat ($urandom_range(60, 0)) step(2'($urandom), 1'b0, 1'b0);
      step(2'($urandom), 1'b1, 1'b0);
      repeat (31) step(2'($urandom), 1'b1, 1'b0);
      #1 chk("rand_k", 32'(gfx.scale_out), 32'(m_k));
      scan("rand_scan");
    end

    // 30 commits of 1..30 on channel 0 wrap the 25-entry ring
    step(2'b00, 1'b0, 1'b1);
    for (int v = 1; v <= 30; v++) begin
      repeat (v) step({1'($urandom), 1'b1}, 1'b0, 1'b0);
      step(2'b00, 1'b1, 1'b0);
      repeat (31) step(2'b00, 1'b1, 1'b0);
    end
    #1 chk("wrap_k", 32'(gfx.scale_out), 32'd5);
    pix_expect("wrap_left", 803, 195, 12'h0F0);
    pix_expect("wrap_right", 995, 45, 12'h0F0);
    pix_check("wrap_past_end", 1000, 45);
    scan("wrap_scan");

    // saturation at 2**TW-1
    step(2'b00, 1'b0, 1'b1);
    repeat (300) step(2'b01, 1'b0, 1'b0);
    step(2'b00, 1'b1, 1'b0);
    #1 chk("sat_k", 32'(gfx.scale_out), 32'd8);
    pix_expect("sat_row", 803, 33, 12'h0F0);

    // clear beats a simultaneous frame_end: divider stays at 0
    step(2'b00, 1'b1, 1'b1);
    #1 chk("clr_k", 32'(gfx.scale_out), 32'd0);
    pix_expect("clr_empty", 803, 33, 12'h000);
    repeat (5) step(2'b01, 1'b0, 1'b0);
    step(2'b00, 1'b1, 1'b0);
    #1 chk("clr_fc0_k", 32'(gfx.scale_out), 32'd3);
    pix_expect("clr_fc0", 803, 107, 12'h0F0);

    // asynchronous reset mid-frame
    @(negedge clk);
    gfx.hcount_in = 11'd803;
    gfx.vcount_in = 10'd107;
    rst_n = 1'b0;
    #1;
    chk("midrst_pix", 32'(gfx.pix_out), 32'h0);
    chk("midrst_scale", 32'(gfx.scale_out), 32'd0);
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pix_expect("midrst_notrace", 803, 107, 12'h000);
    pix_expect("midrst_axis_b", 900, 232, 12'hFFF);
    pix_expect("midrst_axis_l", 800, 200, 12'hFFF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
